// File: rtl/router_fsm_nch.sv
// router_fsm_nch: NUM_CH-way router input FSM; define ROUTER_FSM_TIMEOUT_EN to drop packets stuck in WAIT_TILL_EMPTY.
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic              router_clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic [NUM_CH-1:0] dest_sel,
  output logic              drop_state,
  output logic              pkt_drop
);
  localparam int NE = 2 ** ADDR_W;
  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_pkt_drop;
  logic [NE-1:0]     w_empty, w_srst;
  logic              w_bad, w_timeout;
  assign w_empty = NE'(fifo_empty);
  assign w_srst  = NE'(soft_reset);
  assign w_bad   = {1'b0, data_in} >= (ADDR_W+1)'(NUM_CH);
`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_TIMEOUT) + 1;
  logic [CW-1:0] r_wait;
  assign w_timeout = r_wait == CW'(WAIT_TIMEOUT - 1);
  always_ff @(posedge router_clock)
    if (reset || r_state != WAIT_TILL_EMPTY) r_wait <= '0;
    else r_wait <= r_wait + 1'b1;
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = DECODE_ADDRESS;
    case (r_state)
      DECODE_ADDRESS:     w_next = !pkt_valid ? DECODE_ADDRESS : w_bad ? DROP_PACKET :
                                   w_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    w_next = LOAD_DATA;
      LOAD_DATA:          w_next = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      FIFO_FULL_STATE:    w_next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    w_next = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      WAIT_TILL_EMPTY:    w_next = w_empty[r_addr] ? LOAD_FIRST_DATA : w_timeout ? DROP_PACKET : WAIT_TILL_EMPTY;
      DROP_PACKET:        w_next = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
      default:            w_next = DECODE_ADDRESS;
    endcase
    if (w_srst[r_addr] && r_state != DECODE_ADDRESS && r_state != DROP_PACKET) w_next = DECODE_ADDRESS;
  end
  always_ff @(posedge router_clock) begin
    if (reset) begin
      r_state    <= DECODE_ADDRESS;
      r_addr     <= '0;
      r_pkt_drop <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pkt_drop <= w_next == DROP_PACKET && r_state != DROP_PACKET;
      if (r_state == DECODE_ADDRESS && pkt_valid) r_addr <= data_in;
    end
  end
  assign detect_add    = r_state == DECODE_ADDRESS;
  assign lfd_state     = r_state == LOAD_FIRST_DATA;
  assign ld_state      = r_state == LOAD_DATA;
  assign laf_state     = r_state == LOAD_AFTER_FULL;
  assign full_state    = r_state == FIFO_FULL_STATE;
  assign rst_int_reg   = r_state == CHECK_PARITY_ERROR;
  assign drop_state    = r_state == DROP_PACKET;
  assign pkt_drop      = r_pkt_drop;
  assign write_enb_reg = ld_state || laf_state || r_state == LOAD_PARITY;
  assign busy          = lfd_state || r_state == LOAD_PARITY || full_state || laf_state ||
                         r_state == WAIT_TILL_EMPTY || rst_int_reg;
  assign dest_sel      = (detect_add || drop_state) ? '0 : NUM_CH'(1) << r_addr;
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: randomized cycle-by-cycle comparison against a phase-level router model.
module tb_router_fsm_nch;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;
`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam int WT = 8;
  localparam bit TO = 1'b1;
`else
  localparam int WT = 64;
  localparam bit TO = 1'b0;
`endif
  localparam int OW = 10 + NUM_CH;
  localparam int HDR = 20, FIRST = 21, BODY = 22, PAR = 23, FULL = 24, AFULL = 25, WAITE = 26, CHK = 27, DROP = 28;

  logic clk = 1'b0, reset = 1'b1, pkt_valid = 1'b0, fifo_full = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0;
  logic [ADDR_W-1:0] data_in = '0;
  logic [NUM_CH-1:0] fifo_empty = '0, soft_reset = '0, dest_sel;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, drop_state, pkt_drop;
  int errors = 0, checks = 0;
  int ph = HDR, addr = 0, waited = 0, drop_p = 0, empty_pct = 70;

  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(WT)) dut (
    .router_clock(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .busy(busy),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg),
    .dest_sel(dest_sel), .drop_state(drop_state), .pkt_drop(pkt_drop));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] expected();
    logic [NUM_CH-1:0] d;
    d = (ph == HDR || ph == DROP) ? '0 : NUM_CH'(1) << addr;
    return {ph == FIRST || ph == PAR || ph == FULL || ph == AFULL || ph == WAITE || ph == CHK,
            ph == HDR, ph == FIRST, ph == BODY, ph == AFULL, ph == FULL, ph == CHK,
            ph == BODY || ph == AFULL || ph == PAR, ph == DROP, drop_p == 1, d};
  endfunction

  task automatic model_step();
    int n, din;
    din = int'(data_in);
    if (reset) begin
      ph = HDR; addr = 0; waited = 0; drop_p = 0;
      return;
    end
    case (ph)
      HDR:   n = !pkt_valid ? HDR : din >= NUM_CH ? DROP : fifo_empty[din] ? FIRST : WAITE;
      FIRST: n = BODY;
      BODY:  n = fifo_full ? FULL : pkt_valid ? BODY : PAR;
      PAR:   n = CHK;
      CHK:   n = fifo_full ? FULL : HDR;
      FULL:  n = fifo_full ? FULL : AFULL;
      AFULL: n = parity_done ? HDR : low_pkt_valid ? PAR : BODY;
      WAITE: n = fifo_empty[addr] ? FIRST : (TO && waited + 1 >= WT) ? DROP : WAITE;
      default: n = pkt_valid ? DROP : HDR;
    endcase
    if (ph != HDR && ph != DROP && soft_reset[addr]) n = HDR;
    drop_p = (n == DROP && ph != DROP) ? 1 : 0;
    waited = (ph == WAITE) ? waited + 1 : 0;
    if (ph == HDR && pkt_valid) addr = din;
    ph = n;
  endtask

  function automatic logic pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    model_step();
    @(negedge clk);
    check("reset_outs", 32'({busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                             write_enb_reg, drop_state, pkt_drop, dest_sel}), 32'(expected()));
    reset = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (c % 400 == 0) empty_pct = (empty_pct == 70) ? 3 : 70;
      reset = pct(1) && pct(30);
      pkt_valid = pct(78);
      data_in = ADDR_W'($urandom_range(2 ** ADDR_W - 1));
      for (int k = 0; k < NUM_CH; k++) begin
        fifo_empty[k] = pct(empty_pct);
        soft_reset[k] = pct(3);
      end
      fifo_full = pct(25);
      parity_done = pct(30);
      low_pkt_valid = pct(30);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check($sformatf("outs_c%0d", c),
            32'({busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                 write_enb_reg, drop_state, pkt_drop, dest_sel}), 32'(expected()));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
